// File: rtl/i2s_dac_transmitter_if.sv
// Producer-side bus of the I2S DAC transmitter: sample hand-off plus codec pins.
//
// Sample hand-off: the transmitter latches audio_data (zeroed if mute is set)
// on the Clk edge that starts a frame, then raises sample_clk for exactly one
// cycle. sample_clk means "taken, compute the next one". The producer must
// hold audio_data/mute stable up to the next frame start. There is no
// back-pressure, because the codec frame rate paces the whole pipeline.
interface i2s_dac_transmitter_if #(
  parameter int WORD_BITS = 16
);
  logic                 enable;
  logic                 mute;
  logic [WORD_BITS-1:0] audio_data;
  logic                 sample_clk;
  logic                 frame_active;
  logic                 AUD_BCLK;
  logic                 AUD_DACLRCK;
  logic                 AUD_DACDAT;
  // {stop_pending, running}
  logic [1:0]           dbg_state;

  modport master (
    output enable, mute, audio_data,
    input  sample_clk, frame_active, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, dbg_state
  );

  modport slave (
    input  enable, mute, audio_data,
    output sample_clk, frame_active, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, dbg_state
  );
endinterface

// File: rtl/i2s_dac_transmitter.sv
// I2S DAC transmitter: generates BCLK/DACLRCK from Clk, paces the note producer
// with a one-cycle sample_clk strobe per frame and shifts the latched mono
// sample MSB-first into both channel slots with the I2S one-bit delay.
module i2s_dac_transmitter #(
  parameter int CLK_DIV   = 8,
  parameter int WORD_BITS = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic Clk,
  input  logic Reset,
  i2s_dac_transmitter_if.slave bus
);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_n;
  logic                 stop_pending, stop_pending_n;
  logic [DIV_W-1:0]     div_cnt, div_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [BIT_W-1:0]     slot_pos;
  logic [WORD_BITS-1:0] hold, hold_n;
  logic                 bclk, bclk_n;
  logic                 lrck, lrck_n;
  logic                 dacdat, dacdat_n;
  logic                 pulse, pulse_n;
  logic                 active, active_n;
  logic                 frame_start;

  // State and all output registers; reset forces every output low at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      hold         <= '0;
      bclk         <= 1'b0;
      lrck         <= 1'b0;
      dacdat       <= 1'b0;
      pulse        <= 1'b0;
      active       <= 1'b0;
    end else begin
      state        <= state_n;
      stop_pending <= stop_pending_n;
      div_cnt      <= div_cnt_n;
      bit_cnt      <= bit_cnt_n;
      hold         <= hold_n;
      bclk         <= bclk_n;
      lrck         <= lrck_n;
      dacdat       <= dacdat_n;
      pulse        <= pulse_n;
      active       <= active_n;
    end
  end

  // Next state: divider, bit counter, frame start/stop and next output values.
  always_comb begin
    state_n        = state;
    stop_pending_n = stop_pending;
    div_cnt_n      = div_cnt;
    bit_cnt_n      = bit_cnt;
    hold_n         = hold;
    bclk_n         = bclk;
    pulse_n        = 1'b0;
    active_n       = active;
    frame_start    = 1'b0;
    lrck_n         = 1'b0;
    dacdat_n       = 1'b0;
    slot_pos       = '0;

    case (state)
      IDLE: begin
        stop_pending_n = 1'b0;
        bclk_n         = 1'b0;
        active_n       = 1'b0;
        if (bus.enable) frame_start = 1'b1;
      end
      RUN: begin
        // Only informational: enable is acted on solely at the frame end.
        stop_pending_n = ~bus.enable;
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          bclk_n    = ~bclk;
          if (bclk) begin
            // Fall tick: advance to the next bit or close the frame.
            if (bit_cnt == BIT_LAST) begin
              if (bus.enable) begin
                frame_start = 1'b1;
              end else begin
                state_n        = IDLE;
                bit_cnt_n      = '0;
                bclk_n         = 1'b0;
                active_n       = 1'b0;
                stop_pending_n = 1'b0;
              end
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (frame_start) begin
      state_n        = RUN;
      stop_pending_n = 1'b0;
      bit_cnt_n      = '0;
      div_cnt_n      = '0;
      hold_n         = bus.mute ? '0 : bus.audio_data;
      pulse_n        = 1'b1;
      active_n       = 1'b1;
      bclk_n         = 1'b0;
    end

    // LRCK and data follow the updated bit counter so they move with BCLK fall.
    if (state_n == RUN) begin
      lrck_n   = (bit_cnt_n >= SLOT_B);
      slot_pos = lrck_n ? (bit_cnt_n - SLOT_B) : bit_cnt_n;
      for (int i = 0; i < WORD_BITS; i++) begin
        if (slot_pos == BIT_W'(WORD_BITS - i)) dacdat_n = hold_n[i];
      end
    end
  end

  assign bus.sample_clk   = pulse;
  assign bus.frame_active = active;
  assign bus.AUD_BCLK     = bclk;
  assign bus.AUD_DACLRCK  = lrck;
  assign bus.AUD_DACDAT   = dacdat;
  assign bus.dbg_state    = {stop_pending, (state == RUN)};
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Bench for i2s_dac_transmitter: frame-timing reference model, serial-word
// scoreboard and directed plus randomized enable/mute/data stimulus.
module tb_i2s_dac_transmitter;
  localparam int CLK_DIV   = 2;
  localparam int WORD_BITS = 16;
  localparam int SLOT_BITS = 32;
  localparam int BIT_CYC   = 2 * CLK_DIV;
  localparam int FRAME_LEN = 2 * SLOT_BITS * BIT_CYC;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  i2s_dac_transmitter_if #(.WORD_BITS(WORD_BITS)) bus ();

  i2s_dac_transmitter #(
    .CLK_DIV  (CLK_DIV),
    .WORD_BITS(WORD_BITS),
    .SLOT_BITS(SLOT_BITS)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc++;

  // ---------------- reference model ----------------
  // A frame is FRAME_LEN Clk cycles counted from its start edge; outputs are
  // pure functions of the cycle offset and the word latched at the start.
  logic [WORD_BITS-1:0] exp_q[$];
  bit                   m_run   = 1'b0;
  bit                   m_pulse = 1'b0;
  int                   m_t     = 0;
  logic [WORD_BITS-1:0] m_word  = '0;

  task automatic model_start();
    m_run   = 1'b1;
    m_t     = 0;
    m_word  = bus.mute ? '0 : bus.audio_data;
    m_pulse = 1'b1;
    exp_q.push_back(m_word);
    exp_q.push_back(m_word);
  endtask

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_run   = 1'b0;
      m_t     = 0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (m_run) begin
        m_t++;
        if (m_t == FRAME_LEN) begin
          if (bus.enable) model_start();
          else            m_run = 1'b0;
        end
      end else if (bus.enable) begin
        model_start();
      end
    end
  end

  function automatic logic exp_bclk();
    return m_run && (((m_t / CLK_DIV) % 2) == 1);
  endfunction

  function automatic logic exp_lrck();
    return m_run && ((m_t / BIT_CYC) >= SLOT_BITS);
  endfunction

  function automatic logic exp_dat();
    int s;
    s = (m_t / BIT_CYC) % SLOT_BITS;
    if (!m_run || s < 1 || s > WORD_BITS) return 1'b0;
    return m_word[WORD_BITS - s];
  endfunction

  // ---------------- per-cycle compare and serial scoreboard ----------------
  int                   rc         = 0;
  bit                   prev_bclk  = 1'b0;
  bit                   seen_frame = 1'b0;
  logic [WORD_BITS-1:0] sh         = '0;

  always @(negedge Clk) begin
    check_eq("sample_clk",   bus.sample_clk,   m_pulse);
    check_eq("frame_active", bus.frame_active, m_run);
    check_eq("bclk",         bus.AUD_BCLK,     exp_bclk());
    check_eq("lrck",         bus.AUD_DACLRCK,  exp_lrck());
    check_eq("dacdat",       bus.AUD_DACDAT,   exp_dat());
    check_eq("dbg_run",      bus.dbg_state[0], m_run);
    if (!Reset) begin
      rc         = 0;
      sh         = '0;
      prev_bclk  = 1'b0;
      seen_frame = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.sample_clk) begin
        if (seen_frame) check_eq("rises_per_frame", rc, 2 * SLOT_BITS);
        seen_frame = 1'b1;
        rc = 0;
      end
      if (bus.AUD_BCLK && !prev_bclk) begin
        int s;
        s = rc % SLOT_BITS;
        if (s >= 1 && s <= WORD_BITS) sh = {sh[WORD_BITS-2:0], bus.AUD_DACDAT};
        if (s == WORD_BITS) begin
          check_eq("sb_avail", (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) check_eq("sb_word", sh, exp_q.pop_front());
        end
        rc++;
      end
      prev_bclk = bus.AUD_BCLK;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_t(input int target);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 3 * FRAME_LEN) begin
      @(negedge Clk);
      n++;
      hit = m_run && (m_t == target);
    end
    check_eq("wait_t_reached", hit, 1'b1);
  endtask

  task automatic wait_pulse(input int budget, output int at);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge Clk);
      n++;
      got = bus.sample_clk;
    end
    at = cyc;
    check_eq("pulse_arrived", got, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.frame_active && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check_eq("went_idle", bus.frame_active, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, p0, p1, idle_pulses;
    bus.enable     = 1'b0;
    bus.mute       = 1'b0;
    bus.audio_data = '0;

    // Reset held, then idle with enable low: no activity at all.
    repeat (20) @(negedge Clk);
    Reset = 1'b1;
    idle_pulses = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      if (bus.sample_clk) idle_pulses++;
    end
    check_eq("idle_pulses", idle_pulses, 0);

    // First frame: pulse on the very first enabled edge.
    bus.audio_data = 16'hA5F0;
    bus.enable     = 1'b1;
    c0 = cyc;
    wait_pulse(4, p0);
    check_eq("first_pulse_latency", p0 - c0, 1);

    // Data change mid-frame lands in the next frame only.
    wait_t(100);
    bus.audio_data = 16'h1234;
    wait_pulse(FRAME_LEN + 4, p1);
    check_eq("pulse_period_a", p1 - p0, FRAME_LEN);

    // Mute mid-frame: current frame intact, next frame silent, pulse kept.
    wait_t(60);
    bus.mute       = 1'b1;
    bus.audio_data = 16'h7FFF;
    wait_pulse(FRAME_LEN + 4, p0);
    check_eq("pulse_period_b", p0 - p1, FRAME_LEN);
    wait_t(30);
    bus.mute = 1'b0;
    wait_pulse(FRAME_LEN + 4, p1);
    check_eq("pulse_period_c", p1 - p0, FRAME_LEN);

    // Enable dropped at bit 10: frame completes, then silence.
    wait_t(10 * BIT_CYC + 1);
    bus.enable = 1'b0;
    wait_idle(2 * FRAME_LEN);
    idle_pulses = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      if (bus.sample_clk) idle_pulses++;
    end
    check_eq("stopped_pulses", idle_pulses, 0);
    bus.enable = 1'b1;
    c0 = cyc;
    wait_pulse(4, p0);
    check_eq("restart_latency", p0 - c0, 1);

    // Asynchronous reset mid right slot (bit 40, BCLK high).
    wait_t(40 * BIT_CYC + CLK_DIV);
    #3 Reset = 1'b0;
    #1;
    check_eq("rst_async_bclk",   bus.AUD_BCLK,     1'b0);
    check_eq("rst_async_lrck",   bus.AUD_DACLRCK,  1'b0);
    check_eq("rst_async_dat",    bus.AUD_DACDAT,   1'b0);
    check_eq("rst_async_active", bus.frame_active, 1'b0);
    check_eq("rst_async_pulse",  bus.sample_clk,   1'b0);
    repeat (3) @(negedge Clk);
    bus.audio_data = 16'($urandom);
    Reset = 1'b1;
    c0 = cyc;
    wait_pulse(4, p0);
    check_eq("post_reset_latency", p0 - c0, 1);

    // Randomized data/mute changes with occasional stop/restart.
    for (int f = 0; f < 10; f++) begin
      wait_t($urandom_range(1, FRAME_LEN - 2));
      bus.audio_data = 16'($urandom);
      bus.mute       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        bus.enable = 1'b0;
        wait_idle(2 * FRAME_LEN);
        repeat ($urandom_range(1, 20)) @(negedge Clk);
        bus.enable = 1'b1;
      end
    end

    // Wind down and make sure every latched word was seen on the wire.
    wait_t(FRAME_LEN / 2);
    bus.enable = 1'b0;
    wait_idle(2 * FRAME_LEN);
    repeat (10) @(negedge Clk);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
